// File: rtl/mul_final_cpa_pkg.sv
// Shared multiplier definitions.
// Holds the product width, the split point of the final carry-propagate
// adder, and the redundant sum/carry pair emitted by the compression tree.
package mul_final_cpa_pkg;

  localparam int MUL_PROD_W = 48;
  localparam int MUL_SPLIT  = 24;

  // Redundant tree result: sum bit i has weight 2^i, carry bit i has
  // weight 2^(i+1).
  typedef struct packed {
    logic [MUL_PROD_W-1:0] sum;
    logic [MUL_PROD_W-1:0] carry;
  } mul_sc_pair_t;

endpackage

// File: rtl/mul_final_cpa_cpa_slice.sv
// cpa_slice: W-bit binary adder with carry-in and carry-out.
// Ports:
//   a_i, b_i  W-bit addends
//   cin_i     carry into bit 0
//   sum_o     W-bit sum
//   cout_o    carry out of bit W-1
module cpa_slice #(
  parameter int W = 24
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  logic [W:0] full;

  assign full            = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};
  assign {cout_o, sum_o} = full;

endmodule

// File: rtl/mul_final_cpa.sv
// mul_final_cpa: final carry-propagate stage of the 24x24 mantissa multiplier.
// Resolves the tree's redundant sum/carry pair into a binary product in two
// pipeline stages: the low SPLIT bits are added in stage 1, the high bits in
// stage 2 using the registered carry out of the low half.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    input handshake for in_sum/in_carry
//   in_sum, in_carry     redundant tree result (carry bit i weighs 2^(i+1))
//   out_valid/out_ready  output handshake for out_prod
//   out_prod             (in_sum + 2*in_carry) mod 2^PROD_W
//   out_msb              out_prod[PROD_W-1], normalisation hint
module mul_final_cpa
  import mul_final_cpa_pkg::*;
#(
  parameter int PROD_W = MUL_PROD_W,
  parameter int SPLIT  = MUL_SPLIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_sum,
  input  logic [PROD_W-1:0] in_carry,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_prod,
  output logic              out_msb
);

  localparam int HI_W = PROD_W - SPLIT;

  // Carry vector aligned to its true weight; the top carry bit falls off.
  logic [PROD_W-1:0] carry_sh;
  logic              carry_msb_unused;

  logic [SPLIT-1:0] lo_sum;
  logic             lo_cout;
  logic [HI_W-1:0]  hi_sum;
  logic             hi_cout_unused;

  logic              vld_p1_q, vld_p1_d;
  logic [SPLIT-1:0]  lo_p1_q, lo_p1_d;
  logic              c1_p1_q, c1_p1_d;
  logic [HI_W-1:0]   hs_p1_q, hs_p1_d;
  logic [HI_W-1:0]   hc_p1_q, hc_p1_d;
  logic              vld_p2_q, vld_p2_d;
  logic [PROD_W-1:0] prod_p2_q, prod_p2_d;

  logic s1_move;
  logic in_fire;
  logic adv2;

  assign carry_sh         = {in_carry[PROD_W-2:0], 1'b0};
  assign carry_msb_unused = in_carry[PROD_W-1];

  cpa_slice #(.W(SPLIT)) u_lo (
    .a_i    (in_sum[SPLIT-1:0]),
    .b_i    (carry_sh[SPLIT-1:0]),
    .cin_i  (1'b0),
    .sum_o  (lo_sum),
    .cout_o (lo_cout)
  );

  cpa_slice #(.W(HI_W)) u_hi (
    .a_i    (hs_p1_q),
    .b_i    (hc_p1_q),
    .cin_i  (c1_p1_q),
    .sum_o  (hi_sum),
    .cout_o (hi_cout_unused)
  );

  // Stage 2 can take new data when it is empty or being drained this cycle.
  assign s1_move  = !vld_p2_q || out_ready;
  assign in_ready = rst || !vld_p1_q || s1_move;
  assign in_fire  = in_valid && in_ready;
  assign adv2     = vld_p1_q && s1_move;

  always_comb begin
    vld_p1_d  = vld_p1_q;
    lo_p1_d   = lo_p1_q;
    c1_p1_d   = c1_p1_q;
    hs_p1_d   = hs_p1_q;
    hc_p1_d   = hc_p1_q;
    vld_p2_d  = vld_p2_q;
    prod_p2_d = prod_p2_q;

    // Stage 0 -> 1: low-half add, capture high-half operands.
    if (in_fire) begin
      vld_p1_d = 1'b1;
      lo_p1_d  = lo_sum;
      c1_p1_d  = lo_cout;
      hs_p1_d  = in_sum[PROD_W-1:SPLIT];
      hc_p1_d  = carry_sh[PROD_W-1:SPLIT];
    end else if (s1_move) begin
      vld_p1_d = 1'b0;
    end

    // Stage 1 -> 2: high-half add with the registered inter-half carry.
    if (s1_move) begin
      vld_p2_d = vld_p1_q;
    end
    if (adv2) begin
      prod_p2_d = {hi_sum, lo_p1_q};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q  <= 1'b0;
      lo_p1_q   <= '0;
      c1_p1_q   <= 1'b0;
      hs_p1_q   <= '0;
      hc_p1_q   <= '0;
      vld_p2_q  <= 1'b0;
      prod_p2_q <= '0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      lo_p1_q   <= lo_p1_d;
      c1_p1_q   <= c1_p1_d;
      hs_p1_q   <= hs_p1_d;
      hc_p1_q   <= hc_p1_d;
      vld_p2_q  <= vld_p2_d;
      prod_p2_q <= prod_p2_d;
    end
  end

  assign out_valid = vld_p2_q;
  assign out_prod  = prod_p2_q;
  assign out_msb   = prod_p2_q[PROD_W-1];

endmodule

// File: tb/tb_mul_final_cpa.sv
module tb_mul_final_cpa;

  localparam int W = 48;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_sum;
  logic [W-1:0] in_carry;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_prod;
  logic         out_msb;

  always #5 clk = ~clk;

  mul_final_cpa dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_carry  (in_carry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_prod  (out_prod),
    .out_msb   (out_msb)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int n_out   = 0;

  logic [W-1:0] exp_q[$];
  int           out_cyc[$];
  int           acc_cyc[$];

  function automatic logic [W-1:0] ref_prod(input logic [W-1:0] s, input logic [W-1:0] c);
    logic [W+1:0] t;
    t = {2'b00, s} + ({2'b00, c} << 1);
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] rnd48();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  function automatic void chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endfunction

  // Scoreboard: every accepted input enqueues its expected product; every
  // presented output must match the oldest outstanding expectation.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", W'(1), W'(0));
        end else begin
          chk("sb_prod", out_prod, exp_q[0]);
          chk("sb_msb", W'(out_msb), W'(exp_q[0][W-1]));
        end
      end
      if (out_valid && out_ready && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        out_cyc.push_back(cyc);
        n_out++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_prod(in_sum, in_carry));
        acc_cyc.push_back(cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] s, input logic [W-1:0] c);
    int  waited;
    bit  done;
    in_valid = 1'b1;
    in_sum   = s;
    in_carry = c;
    waited   = 0;
    done     = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      else begin
        waited++;
        if (waited > 50) begin
          chk("push_timeout", W'(0), W'(1));
          done = 1'b1;
        end else begin
          step();
        end
      end
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string nm, input logic [W-1:0] exp);
    step();
    chk({nm, "_valid"}, W'(out_valid), W'(1));
    chk(nm, out_prod, exp);
    chk({nm, "_msb"}, W'(out_msb), W'(exp[W-1]));
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      step();
      k++;
    end
    chk("drain_empty", W'(exp_q.size()), W'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] bs[4];
    logic [W-1:0] bc[4];
    logic [W-1:0] held;
    logic [W-1:0] s, c;
    int idx, k, base, abase;
    bit acc;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_sum = '0; in_carry = '0;
    repeat (3) step();
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_out_prod", out_prod, W'(0));
    chk("rst_out_msb", W'(out_msb), W'(0));
    rst = 1'b0;
    step();
    chk("post_rst_out_valid", W'(out_valid), W'(0));
    chk("post_rst_in_ready", W'(in_ready), W'(1));

    // Directed literal cases with a free-flowing output.
    out_ready = 1'b1;
    push(48'h000000FFFFFF, 48'h000000000001);
    expect_out("boundary", 48'h000001000001);
    push(48'hFFFFFE000001, 48'h0);
    expect_out("fullscale", 48'hFFFFFE000001);
    chk("fullscale_msb_lit", W'(out_msb), W'(1));
    push(48'h7FFFFF000000, 48'h0);
    expect_out("msb_clear", 48'h7FFFFF000000);
    chk("msb_clear_lit", W'(out_msb), W'(0));
    push(48'hFFFFFFFFFFFF, 48'h800000000001);
    expect_out("wrap", 48'h000000000001);
    step(); step();

    // Backpressure: four back-to-back inputs against a stalled output.
    for (int i = 0; i < 4; i++) begin
      bs[i] = rnd48();
      bc[i] = rnd48();
    end
    base = n_out;
    out_ready = 1'b0; idx = 0;
    in_valid = 1'b1; in_sum = bs[0]; in_carry = bc[0];
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      acc = in_ready;
      step();
      if (acc) begin
        idx++;
        if (idx < 4) begin in_sum = bs[idx]; in_carry = bc[idx]; end
        else in_valid = 1'b0;
      end
    end
    chk("bp_accepted", W'(idx), W'(2));
    @(negedge clk);
    chk("bp_in_ready_low", W'(in_ready), W'(0));
    chk("bp_out_valid", W'(out_valid), W'(1));
    held = out_prod;
    repeat (3) step();
    chk("bp_hold", out_prod, held);
    chk("bp_first_value", out_prod, ref_prod(bs[0], bc[0]));
    out_ready = 1'b1;
    k = 0;
    while (idx < 4 && k < 50) begin
      @(negedge clk);
      acc = in_ready;
      step();
      if (acc) begin
        idx++;
        if (idx < 4) begin in_sum = bs[idx]; in_carry = bc[idx]; end
        else in_valid = 1'b0;
      end
      k++;
    end
    in_valid = 1'b0;
    drain();
    chk("bp_count", W'(n_out - base), W'(4));

    // Full-rate streaming of 100 random pairs.
    base = n_out; abase = acc_cyc.size();
    out_ready = 1'b1; idx = 0; k = 0;
    s = rnd48(); c = rnd48();
    in_valid = 1'b1; in_sum = s; in_carry = c;
    while (idx < 100 && k < 400) begin
      @(negedge clk);
      acc = in_ready;
      step();
      if (acc) begin
        idx++;
        if (idx < 100) begin in_sum = rnd48(); in_carry = rnd48(); end
        else in_valid = 1'b0;
      end
      k++;
    end
    in_valid = 1'b0;
    chk("tp_no_stall", W'(k), W'(100));
    drain();
    chk("tp_count", W'(n_out - base), W'(100));
    if (out_cyc.size() >= base + 100 && acc_cyc.size() > abase) begin
      chk("tp_latency", W'(out_cyc[base] - acc_cyc[abase]), W'(2));
      chk("tp_back_to_back", W'(out_cyc[base+99] - out_cyc[base]), W'(99));
    end else begin
      chk("tp_outputs_present", W'(0), W'(1));
    end

    // Reset with two results in flight.
    out_ready = 1'b0;
    push(rnd48(), rnd48());
    push(rnd48(), rnd48());
    base = n_out;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_out_valid", W'(out_valid), W'(0));
    chk("midrst_out_prod", out_prod, W'(0));
    chk("midrst_in_ready", W'(in_ready), W'(1));
    chk("midrst_out_msb", W'(out_msb), W'(0));
    out_ready = 1'b1;
    repeat (6) step();
    chk("midrst_no_ghost", W'(n_out - base), W'(0));

    // Normal operation resumes after reset.
    s = rnd48(); c = rnd48();
    push(s, c);
    expect_out("after_rst", ref_prod(s, c));
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
